// File: rtl/ex_div_sched.sv
// Sequencer that time-shares one radix-2 restoring divider across all EX issue
// lanes, serving requesting lanes in ascending index and stalling until all finish.
module ex_div_sched #(
  parameter int CONFIG_P_ISSUE_WIDTH = 0,
  parameter int CONFIG_DW            = 64,
  localparam int IW                  = 1 << CONFIG_P_ISSUE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    stall,
  input  logic [IW-1:0]           ex_valid,
  input  logic [IW-1:0]           ex_div_req,
  input  logic [IW-1:0]           ex_div_signed,
  input  logic [IW-1:0]           ex_div_rem,
  input  logic [CONFIG_DW*IW-1:0] ex_operand1,
  input  logic [CONFIG_DW*IW-1:0] ex_operand2,
  output logic                    div_stall,
  output logic [CONFIG_DW*IW-1:0] div_result,
  output logic [IW-1:0]           div_done
);

  localparam int DW = CONFIG_DW;
  localparam int SW = (CONFIG_P_ISSUE_WIDTH > 0) ? CONFIG_P_ISSUE_WIDTH : 1;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t        state;
  logic [IW-1:0] done_vec;
  logic [SW-1:0] cur_sel;
  logic [CW-1:0] cnt;
  logic [DW-1:0] quo;
  logic [DW-1:0] part_rem;
  logic [DW-1:0] divisor;
  logic [DW-1:0] raw_a;
  logic          neg_q;
  logic          neg_r;
  logic          dz;
  logic          rem_op;

  logic [IW-1:0] req;
  logic [IW-1:0] pend;
  logic [IW-1:0] cand;
  logic [SW-1:0] nxt_sel;
  logic          load;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          nxt_signed;
  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [DW:0]   trial;
  logic [DW-1:0] q_fix;
  logic [DW-1:0] r_fix;
  logic [DW-1:0] res_fix;

  always_comb begin
    req  = ex_valid & ex_div_req;
    pend = req & ~done_vec;
    cand = pend;
    // In FIX the lane just finishing is not yet in done_vec, so mask it here.
    if (state == FIX) cand[cur_sel] = 1'b0;

    nxt_sel = '0;
    for (int i = IW - 1; i >= 0; i--) begin
      if (cand[i]) nxt_sel = SW'(i);
    end
    load = ((state == IDLE) || (state == FIX)) && (|cand);

    op_a       = ex_operand1[nxt_sel*DW +: DW];
    op_b       = ex_operand2[nxt_sel*DW +: DW];
    nxt_signed = ex_div_signed[nxt_sel];
    a_neg      = nxt_signed & op_a[DW-1];
    b_neg      = nxt_signed & op_b[DW-1];
    mag_a      = a_neg ? -op_a : op_a;
    mag_b      = b_neg ? -op_b : op_b;

    // Trial subtract of the shifted partial remainder; trial[DW] is the borrow.
    trial   = {part_rem, quo[DW-1]} - {1'b0, divisor};
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -part_rem : part_rem;
    res_fix = dz ? (rem_op ? raw_a : '1) : (rem_op ? r_fix : q_fix);
  end

  assign div_stall = rst && (|req) && (state != DONE);
  assign div_done  = (state == DONE) ? (done_vec & req) : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers are reset too; they are few and a known
      // value keeps div_result defined from the first cycle.
      state      <= IDLE;
      done_vec   <= '0;
      cur_sel    <= '0;
      cnt        <= '0;
      quo        <= '0;
      part_rem   <= '0;
      divisor    <= '0;
      raw_a      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dz         <= 1'b0;
      rem_op     <= 1'b0;
      div_result <= '0;
    end else if (flush) begin
      state    <= IDLE;
      done_vec <= '0;
    end else begin
      case (state)
        IDLE: if (load) state <= ITER;
        ITER: begin
          part_rem <= trial[DW] ? {part_rem[DW-2:0], quo[DW-1]} : trial[DW-1:0];
          quo      <= {quo[DW-2:0], ~trial[DW]};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          div_result[cur_sel*DW +: DW] <= res_fix;
          done_vec[cur_sel]            <= 1'b1;
          state                        <= load ? ITER : DONE;
        end
        DONE: begin
          if (!stall) begin
            state    <= IDLE;
            done_vec <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // Capture the next lane's operands; shared by IDLE and the FIX hand-off.
      if (load) begin
        cur_sel  <= nxt_sel;
        quo      <= mag_a;
        part_rem <= '0;
        divisor  <= mag_b;
        raw_a    <= op_a;
        neg_q    <= nxt_signed & (a_neg ^ b_neg);
        neg_r    <= a_neg;
        dz       <= (op_b == '0);
        rem_op   <= ex_div_rem[nxt_sel];
        cnt      <= CW'(DW - 1);
      end
    end
  end

endmodule

// File: tb/tb_ex_div_sched.sv
// Scoreboard bench for ex_div_sched at DW=8, two lanes: directed divide vectors,
// lane ordering, timing, divide-by-zero, overflow, stall hold, flush and async reset.
module tb_ex_div_sched;

  localparam int P  = 1;
  localparam int DW = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             stall;
  logic [IW-1:0]    ex_valid;
  logic [IW-1:0]    ex_div_req;
  logic [IW-1:0]    ex_div_signed;
  logic [IW-1:0]    ex_div_rem;
  logic [DW*IW-1:0] ex_operand1;
  logic [DW*IW-1:0] ex_operand2;
  logic             div_stall;
  logic [DW*IW-1:0] div_result;
  logic [IW-1:0]    div_done;

  typedef struct {
    logic [1:0] mask;
    logic [7:0] r0;
    logic [7:0] r1;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  ex_div_sched #(.CONFIG_P_ISSUE_WIDTH(P), .CONFIG_DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_div_req   (ex_div_req),
    .ex_div_signed(ex_div_signed),
    .ex_div_rem   (ex_div_rem),
    .ex_operand1  (ex_operand1),
    .ex_operand2  (ex_operand2),
    .div_stall    (div_stall),
    .div_result   (div_result),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [1:0] valid, input logic [1:0] dreq,
                            input logic [1:0] sgn, input logic [1:0] rem,
                            input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1);
    ex_valid      = valid;
    ex_div_req    = dreq;
    ex_div_signed = sgn;
    ex_div_rem    = rem;
    ex_operand1   = {a1, a0};
    ex_operand2   = {b1, b0};
  endtask

  // Called just after the edge that starts cycle 0; returns on the DONE cycle.
  task automatic wait_done(input int ecyc, input string name);
    int cyc    = 0;
    int stallc = 0;
    while (1) begin
      @(negedge clk);
      if (div_done != 2'b00) break;
      if (cyc >= 300) break;
      if (div_stall) stallc++;
      cyc++;
    end
    check({name, " done_cycle"}, 64'(cyc), 64'(ecyc));
    check({name, " stall_cycles"}, 64'(stallc), 64'(ecyc));
    check({name, " stall_low_in_done"}, 64'(div_stall), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] valid, input logic [1:0] dreq,
                        input logic [1:0] sgn, input logic [1:0] rem,
                        input logic [7:0] a0, input logic [7:0] b0,
                        input logic [7:0] a1, input logic [7:0] b1,
                        input logic [1:0] emask, input logic [7:0] e0, input logic [7:0] e1,
                        input int ecyc);
    exp_t e;
    e.mask = emask;
    e.r0   = e0;
    e.r1   = e1;
    sb.push_back(e);
    @(posedge clk); #1;
    set_inputs(valid, dreq, sgn, rem, a0, b0, a1, b1);
    wait_done(ecyc, name);
    @(posedge clk); #1;
    // Back in IDLE with the same requests still present: done cleared, stall re-raised.
    check({name, " idle_done"}, 64'(div_done), 64'd0);
    check({name, " idle_restall"}, 64'(div_stall), 64'd1);
    ex_valid   = '0;
    ex_div_req = '0;
  endtask

  // Monitor: one scoreboard pop per DONE episode, however long stall holds it.
  initial begin
    bit   seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (div_done != 2'b00) begin
        if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            check("sb_unexpected_done", 64'(div_done), 64'd0);
          end else begin
            e = sb.pop_front();
            check("sb_done_mask", 64'(div_done), 64'(e.mask));
            if (e.mask[0]) check("sb_lane0_result", 64'(div_result[7:0]), 64'(e.r0));
            if (e.mask[1]) check("sb_lane1_result", 64'(div_result[15:8]), 64'(e.r1));
          end
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    set_inputs(2'b11, 2'b11, 2'b00, 2'b00, 8'd1, 8'd1, 8'd1, 8'd1);
    #22;
    check("reset div_stall", 64'(div_stall), 64'd0);
    check("reset div_done", 64'(div_done), 64'd0);
    check("reset div_result", 64'(div_result), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    set_inputs(2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

    // Lane1 carries a div op but is not valid, so only lane0 is served.
    run_op("divu_200_7", 2'b01, 2'b11, 2'b00, 2'b00, 8'd200, 8'd7, 8'd9, 8'd3,
           2'b01, 8'h1C, 8'h00, 10);
    run_op("signed_m100_7", 2'b11, 2'b11, 2'b11, 2'b10, 8'h9C, 8'd7, 8'h9C, 8'd7,
           2'b11, 8'hF2, 8'hFE, 19);
    run_op("div_by_zero", 2'b11, 2'b11, 2'b11, 2'b10, 8'h9C, 8'h00, 8'h9C, 8'h00,
           2'b11, 8'hFF, 8'h9C, 19);
    run_op("divu_5_0_lane1", 2'b10, 2'b10, 2'b00, 2'b00, 8'd0, 8'd0, 8'd5, 8'd0,
           2'b10, 8'h00, 8'hFF, 10);
    run_op("min_by_m1", 2'b11, 2'b11, 2'b11, 2'b10, 8'h80, 8'hFF, 8'h80, 8'hFF,
           2'b11, 8'h80, 8'h00, 19);
    run_op("unsigned_mix", 2'b11, 2'b11, 2'b00, 2'b01, 8'd255, 8'd16, 8'd3, 8'd9,
           2'b11, 8'h0F, 8'h00, 19);
    run_op("signed_7_m2", 2'b11, 2'b11, 2'b11, 2'b10, 8'h07, 8'hFE, 8'h07, 8'hFE,
           2'b11, 8'hFD, 8'h01, 19);

    // External stall holds DONE with outputs frozen for three cycles.
    begin
      exp_t e;
      e.mask = 2'b11; e.r0 = 8'h0A; e.r1 = 8'h00;
      sb.push_back(e);
      stall = 1'b1;
      @(posedge clk); #1;
      set_inputs(2'b11, 2'b11, 2'b00, 2'b10, 8'd100, 8'd10, 8'd100, 8'd10);
      wait_done(19, "stall_op");
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("stall_hold div_done", 64'(div_done), 64'h3);
        check("stall_hold div_result", 64'(div_result), 64'h000A);
        check("stall_hold div_stall", 64'(div_stall), 64'd0);
      end
      @(posedge clk); #1;
      stall = 1'b0;
      @(posedge clk); #1;
      check("stall_release idle_done", 64'(div_done), 64'd0);
      check("stall_release restall", 64'(div_stall), 64'd1);
      ex_valid   = '0;
      ex_div_req = '0;
    end

    // Flush during lane1 ITER (cycle 12): back to IDLE at 13, lane0 restarts.
    begin
      exp_t e;
      e.mask = 2'b11; e.r0 = 8'd10; e.r1 = 8'd2;
      sb.push_back(e);
      @(posedge clk); #1;
      set_inputs(2'b11, 2'b11, 2'b00, 2'b10, 8'd50, 8'd5, 8'd50, 8'd6);
      repeat (12) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush idle_done", 64'(div_done), 64'd0);
      check("flush restall", 64'(div_stall), 64'd1);
      wait_done(19, "flush_restart");
      @(posedge clk); #1;
      ex_valid   = '0;
      ex_div_req = '0;
    end

    // Async reset mid-ITER clears outputs without waiting for a clock edge.
    @(posedge clk); #1;
    set_inputs(2'b01, 2'b01, 2'b00, 2'b00, 8'd100, 8'd3, 8'd0, 8'd0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset div_stall", 64'(div_stall), 64'd0);
    check("async_reset div_done", 64'(div_done), 64'd0);
    check("async_reset div_result", 64'(div_result), 64'd0);
    @(negedge clk);
    ex_valid   = '0;
    ex_div_req = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("after_reset div_done", 64'(div_done), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
